// File: rtl/ff_bank_load_ctrl_pkg.sv
// Shared constants and types for the serial-load controller of the 8-cell FF bank.
// Holds the state encoding, bank geometry, timeout limit and the Moore flag decode.
package ff_bank_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam int         BANK_BITS = 8;
    localparam logic [3:0] TMO_LIMIT = 4'd14;

    typedef struct packed {
        logic busy;
        logic done;
        logic error;
    } flags_t;

    // Moore flags for a given state; registered alongside the state itself.
    function automatic flags_t flags_of(input state_t s);
        flags_t f;
        f = '{busy: 1'b0, done: 1'b0, error: 1'b0};
        case (s)
            ST_LOAD: f.busy  = 1'b1;
            ST_DONE: f.done  = 1'b1;
            ST_ERR:  f.error = 1'b1;
            default: f = '{busy: 1'b0, done: 1'b0, error: 1'b0};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ff_bank_load_ctrl_if.sv
// Control/data bundle between the serial source, the load controller and the byte consumer.
interface ff_bank_load_ctrl_if;

    logic       START;
    logic       ABORT;
    logic       DIN_VALID;
    logic       DIN;
    logic [7:0] Q_BANK;
    logic [2:0] BIT_IDX;
    logic       BUSY;
    logic       DONE;
    logic       ERROR;

    modport master (
        output START, ABORT, DIN_VALID, DIN,
        input  Q_BANK, BIT_IDX, BUSY, DONE, ERROR
    );

    modport slave (
        input  START, ABORT, DIN_VALID, DIN,
        output Q_BANK, BIT_IDX, BUSY, DONE, ERROR
    );

endinterface

// File: rtl/ff_bank_load_ctrl_ff.sv
// The team's 1-bit enable flip-flop cell; intentionally has no reset of its own.
module FF (
    input  logic CLK,
    input  logic EN,
    input  logic D,
    output logic Q
);

    // Capture D only when enabled.
    always_ff @(posedge CLK) begin
        if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/ff_bank_load_ctrl.sv
// Serial-to-parallel load controller: steers one valid serial bit per cycle into FF cell i,
// LSB first, and reports completion, abort and idle timeout.
module ff_bank_load_ctrl
    import ff_bank_load_ctrl_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    ff_bank_load_ctrl_if.slave  bus
);

    state_t                 state_r;
    logic [2:0]             bit_idx_r;
    logic [3:0]             tmo_r;
    flags_t                 flags_r;
    logic                   load_wr_s;
    logic [BANK_BITS-1:0]   en_s;
    logic [BANK_BITS-1:0]   d_s;
    logic [BANK_BITS-1:0]   q_s;

    // ABORT outranks a valid bit, so an aborting cycle writes no cell.
    always_comb begin
        load_wr_s = (state_r == ST_LOAD) && bus.DIN_VALID && !bus.ABORT;
    end

    // Per-cell enable/data: RESET clears the reset-less cells, otherwise one-hot write at BIT_IDX.
    always_comb begin
        en_s = '0;
        d_s  = '0;
        if (RESET) begin
            en_s = '1;
            d_s  = '0;
        end else begin
            for (int k = 0; k < BANK_BITS; k++) begin
                en_s[k] = load_wr_s && (bit_idx_r == 3'(k));
            end
            d_s = {BANK_BITS{bus.DIN}};
        end
    end

    for (genvar g = 0; g < BANK_BITS; g++) begin : g_cell
        FF u_cell (
            .CLK (CLK),
            .EN  (en_s[g]),
            .D   (d_s[g]),
            .Q   (q_s[g])
        );
    end

    // Controller FSM with counters and registered Moore flags; priority RESET > ABORT > START > DIN_VALID.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            flags_r   <= flags_of(ST_IDLE);
            bit_idx_r <= 3'd0;
            tmo_r     <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!bus.ABORT && bus.START) begin
                        state_r   <= ST_LOAD;
                        flags_r   <= flags_of(ST_LOAD);
                        bit_idx_r <= 3'd0;
                        tmo_r     <= 4'd0;
                    end
                end
                ST_LOAD: begin
                    if (bus.ABORT) begin
                        state_r <= ST_IDLE;
                        flags_r <= flags_of(ST_IDLE);
                    end else if (bus.DIN_VALID) begin
                        bit_idx_r <= bit_idx_r + 3'd1;
                        tmo_r     <= 4'd0;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= ST_DONE;
                            flags_r <= flags_of(ST_DONE);
                        end
                    end else if (tmo_r == TMO_LIMIT) begin
                        state_r <= ST_ERR;
                        flags_r <= flags_of(ST_ERR);
                    end else begin
                        tmo_r <= tmo_r + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (!bus.ABORT && bus.START) begin
                        state_r   <= ST_LOAD;
                        flags_r   <= flags_of(ST_LOAD);
                        bit_idx_r <= 3'd0;
                        tmo_r     <= 4'd0;
                    end else begin
                        state_r <= ST_IDLE;
                        flags_r <= flags_of(ST_IDLE);
                    end
                end
                ST_ERR: begin
                    if (bus.ABORT) begin
                        state_r <= ST_IDLE;
                        flags_r <= flags_of(ST_IDLE);
                    end else if (bus.START) begin
                        state_r   <= ST_LOAD;
                        flags_r   <= flags_of(ST_LOAD);
                        bit_idx_r <= 3'd0;
                        tmo_r     <= 4'd0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    flags_r <= flags_of(ST_IDLE);
                end
            endcase
        end
    end

    // Outputs are direct register/cell values with no combinational path from inputs.
    always_comb begin
        bus.Q_BANK  = q_s;
        bus.BIT_IDX = bit_idx_r;
        bus.BUSY    = flags_r.busy;
        bus.DONE    = flags_r.done;
        bus.ERROR   = flags_r.error;
    end

endmodule

// File: tb/tb_ff_bank_load_ctrl.sv
// Self-checking bench for ff_bank_load_ctrl: scoreboarded byte loads plus directed timeout/abort/reset cases.
module tb_ff_bank_load_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;
    logic [7:0] exp_q[$];

    ff_bank_load_ctrl_if bus ();

    ff_bank_load_ctrl dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: every DONE pulse must match the next queued byte.
    always @(negedge clk) begin
        if (bus.DONE === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk_val("done_unexpected", 32'd1, 32'd0);
            end else begin
                chk_val("sb_byte", {24'd0, bus.Q_BANK}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    // Send nbits of b LSB first; gaps inserts one invalid cycle (random DIN) before each bit.
    task automatic send_bits(input logic [7:0] b, input int nbits, input bit gaps);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                bus.DIN_VALID = 1'b0;
                bus.DIN       = 1'($urandom_range(0, 1));
                tick();
            end
            chk_val("busy_in_load", {31'd0, bus.BUSY}, 32'd1);
            bus.DIN_VALID = 1'b1;
            bus.DIN       = b[i];
            tick();
        end
        bus.DIN_VALID = 1'b0;
        bus.DIN       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.DIN_VALID = 1'b0; bus.DIN = 1'b0;
        tick();

        // 1: reset state, then back-to-back valid bits.
        do_reset();
        chk_val("rst_q",     {24'd0, bus.Q_BANK}, 32'h00);
        chk_val("rst_idx",   {29'd0, bus.BIT_IDX}, 32'd0);
        chk_val("rst_flags", {29'd0, bus.BUSY, bus.DONE, bus.ERROR}, 32'd0);
        do_start();
        exp_q.push_back(8'h4D);
        send_bits(8'h4D, 8, 1'b0);
        chk_val("t1_done", {31'd0, bus.DONE}, 32'd1);
        chk_val("t1_busy_low", {31'd0, bus.BUSY}, 32'd0);
        tick();
        chk_val("t1_done_one_cycle", {31'd0, bus.DONE}, 32'd0);

        // 2: alternate-cycle valid with noisy DIN on gaps.
        do_start();
        exp_q.push_back(8'h4D);
        send_bits(8'h4D, 8, 1'b1);
        chk_val("t2_done",  {31'd0, bus.DONE}, 32'd1);
        chk_val("t2_error", {31'd0, bus.ERROR}, 32'd0);
        tick();

        // 3: timeout after 15 idle cycles, then ABORT clears it.
        do_reset();
        do_start();
        send_bits(8'h07, 3, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        chk_val("t3_no_err_14", {30'd0, bus.BUSY, bus.ERROR}, 32'd2);
        tick();
        chk_val("t3_err",  {30'd0, bus.BUSY, bus.ERROR}, 32'd1);
        chk_val("t3_q",    {24'd0, bus.Q_BANK}, 32'h07);
        tick();
        chk_val("t3_err_sticky", {31'd0, bus.ERROR}, 32'd1);
        bus.ABORT = 1'b1; tick(); bus.ABORT = 1'b0;
        chk_val("t3_abort", {29'd0, bus.BUSY, bus.DONE, bus.ERROR}, 32'd0);

        // 4: abort mid-load keeps partial bank; next load of zeros completes.
        do_start();
        send_bits(8'h0F, 4, 1'b0);
        bus.ABORT = 1'b1; tick(); bus.ABORT = 1'b0;
        chk_val("t4_idle", {31'd0, bus.BUSY}, 32'd0);
        chk_val("t4_q",    {24'd0, bus.Q_BANK}, 32'h0F);
        do_start();
        exp_q.push_back(8'h00);
        send_bits(8'h00, 8, 1'b0);
        chk_val("t4_done", {31'd0, bus.DONE}, 32'd1);
        tick();

        // 5: RESET mid-load clears bank and controller; valid bits afterwards are ignored.
        do_start();
        send_bits(8'h1F, 5, 1'b0);
        chk_val("t5_q_partial", {24'd0, bus.Q_BANK}, 32'h1F);
        do_reset();
        chk_val("t5_q",     {24'd0, bus.Q_BANK}, 32'h00);
        chk_val("t5_idx",   {29'd0, bus.BIT_IDX}, 32'd0);
        chk_val("t5_flags", {29'd0, bus.BUSY, bus.DONE, bus.ERROR}, 32'd0);
        bus.DIN_VALID = 1'b1; bus.DIN = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        bus.DIN_VALID = 1'b0; bus.DIN = 1'b0;
        chk_val("t5_ignored", {23'd0, bus.BUSY, bus.Q_BANK}, 32'h000);

        // 6: ABORT beats START in IDLE; START during DONE chains a second load.
        bus.START = 1'b1; bus.ABORT = 1'b1; tick();
        bus.START = 1'b0; bus.ABORT = 1'b0;
        chk_val("t6_abort_wins", {31'd0, bus.BUSY}, 32'd0);
        do_start();
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 8, 1'b0);
        chk_val("t6_done1", {31'd0, bus.DONE}, 32'd1);
        do_start();
        chk_val("t6_b2b", {28'd0, bus.BUSY, bus.BIT_IDX}, 32'h8);
        exp_q.push_back(8'h3C);
        send_bits(8'h3C, 8, 1'b0);
        chk_val("t6_done2", {31'd0, bus.DONE}, 32'd1);
        tick();
        tick();

        chk_val("sb_empty",   exp_q.size(), 32'd0);
        chk_val("done_count", n_done, 32'd5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ff_bank_load_ctrl.md
Name: ff_bank_load_ctrl

Overview:
Serial-load controller for an 8-cell bank of the team's 1-bit enable flip-flop cell FF (ports CLK, EN, D, Q).
- Accepts a serial bit stream with a valid strobe.
- Sequences the per-cell enables so bit i lands in cell i, LSB first.
- Reports completion, abort and timeout.
- Sits between a serial receiver and any logic consuming the parallel byte.

Parameters:
none. Widths are fixed and the module is unparameterized; the synthesis flow requires unparameterized modules.

Ports:
CLK        input   1  rising-edge clock
RESET      input   1  synchronous, active-high reset
START      input   1  begin a new 8-bit load
ABORT      input   1  cancel load or clear error, return to IDLE
DIN_VALID  input   1  DIN carries a valid bit this cycle
DIN        input   1  serial data bit
Q_BANK     output  8  parallel outputs of the 8 FF cells (Q_BANK[i] = cell i Q)
BIT_IDX    output  3  index of the next cell to be written
BUSY       output  1  high in LOAD
DONE       output  1  one-cycle pulse after the 8th bit is stored
ERROR      output  1  timeout flag, sticky until START or ABORT

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
  - Reset state: STATE=IDLE, BIT_IDX=0, TMO_CNT=0, BUSY=0, DONE=0, ERROR=0.
  - FF cells have no reset. While RESET=1 the controller drives all cell EN=1 and D=0, so Q_BANK=8'h00 after the first RESET edge.
- Priority per edge: RESET > ABORT > START > DIN_VALID.
- FSM states (2-bit): IDLE=0, LOAD=1, DONE=2, ERR=3.
- IDLE: all flags 0.
  - START=1 -> LOAD; BIT_IDX<=0, TMO_CNT<=0.
  - DIN_VALID is ignored.
  - Q_BANK holds its value.
- LOAD: BUSY=1.
  - Cell enable EN[k] = DIN_VALID & (BIT_IDX==k), decoded combinationally. Cell D = DIN for all cells.
  - Accepted bit (DIN_VALID=1): Q_BANK[BIT_IDX] updates at that edge. BIT_IDX<=BIT_IDX+1 and TMO_CNT<=0.
  - If BIT_IDX==7 on an accepted bit -> DONE state; BIT_IDX wraps to 0.
  - Idle cycle (DIN_VALID=0): TMO_CNT<=TMO_CNT+1 (4-bit). On the 15th consecutive idle cycle (TMO_CNT==14 at that edge) -> ERR.
  - START while in LOAD is ignored.
  - ABORT -> IDLE. Cells already written keep their values.
- DONE state: lasts exactly one cycle. DONE=1, BUSY=0, Q_BANK holds the complete byte.
  - START in this cycle -> LOAD (back-to-back loads); otherwise -> IDLE.
- ERR: ERROR=1, BUSY=0. Partial bank contents are kept; no cell enables are asserted.
  - START -> LOAD with counters cleared and ERROR<=0.
  - ABORT -> IDLE with ERROR<=0.
- Latency: bit accepted at edge n is visible on Q_BANK after edge n. DONE=1 in the cycle after the 8th accepted bit.
- BUSY, DONE and ERROR are Moore outputs decoded from STATE; there is no glitch path from the inputs.
- Cell enables are asserted only in LOAD or during RESET.

Decomposition:
- Shared constants file holds:
  - state encodings ST_IDLE, ST_LOAD, ST_DONE, ST_ERR
  - BANK_BITS=8
  - TMO_LIMIT=14
- Sub-module: the existing FF cell, instantiated 8 times with EN/D driven by the controller.
- No further sub-modules. The counter and one-hot decode stay inline.

Test Plan:
1. RESET, START, then 8 consecutive valid bits 1,0,1,1,0,0,1,0 -> BUSY high 8 cycles; Q_BANK=8'h4D; DONE=1 for exactly one cycle following the 8th edge.
2. Same stream with DIN_VALID on alternate cycles, DIN toggled randomly on invalid cycles -> Q_BANK=8'h4D, DONE after 16 LOAD cycles, ERROR=0.
3. RESET, START, bits 1,1,1, then 15 idle cycles -> ERROR=1, BUSY=0, Q_BANK=8'h07. A subsequent ABORT -> ERROR=0, state IDLE.
4. START, 4 bits of 1, ABORT -> IDLE, Q_BANK=8'h0F. START plus 8 zeros -> Q_BANK=8'h00, DONE pulse.
5. START, 5 bits of 1, RESET for one cycle -> next cycle Q_BANK=8'h00, BIT_IDX=0, BUSY=DONE=ERROR=0. DIN_VALID afterwards has no effect.
6. START with ABORT high in IDLE -> stays IDLE. START held high during the DONE cycle -> back-to-back load begins with BIT_IDX=0.
